// File: rtl/complement_to_magni_serial.sv
// ---------------------------------------------------------------------------
// complement_to_magni_serial
//
// Converts a WIDTH-bit two's-complement word into sign-magnitude form.
// Non-negative words pass straight through. Negative words are negated
// bit-serially, LSB first, by copying bits up to and including the first 1
// and inverting every bit after it. No WIDTH-wide adder is used.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   compl holds a word to convert
//   in_ready   block can accept a word this cycle (state is IDLE)
//   compl      two's-complement operand
//   out_valid  magni/ovf hold a result
//   out_ready  downstream accepts the result this cycle
//   magni      sign-magnitude result, bit WIDTH-1 is the sign
//   ovf        input was the most negative value (not representable)
//   busy       conversion in progress (state is not IDLE)
// ---------------------------------------------------------------------------
module complement_to_magni_serial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] compl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] magni,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Counter must hold 0..WIDTH-2; keep at least one bit when WIDTH is 2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-2:0] result;
  logic [CW-1:0]    cnt;
  logic             seen_one;

  logic             b;
  logic             res_bit;
  logic [WIDTH-1:0] res_ext;
  logic [WIDTH-2:0] result_next;
  logic             seen_next;

  // One step of the serial negation. The new bit enters from the MSB side,
  // so after WIDTH-1 steps the first processed bit has reached the LSB.
  // Building res_ext first keeps the shift legal even when WIDTH is 2.
  always_comb begin
    b           = shreg[0];
    res_bit     = seen_one ? ~b : b;
    res_ext     = {res_bit, result};
    result_next = res_ext[WIDTH-1:1];
    seen_next   = seen_one | b;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Control FSM and datapath. magni/ovf only change when a finished result
  // is loaded, so they stay stable while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      result    <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
      magni     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg    <= compl[WIDTH-2:0];
            result   <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            if (compl[WIDTH-1]) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              magni     <= compl;
              ovf       <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg    <= shreg >> 1;
          result   <= result_next;
          seen_one <= seen_next;
          cnt      <= cnt + 1'b1;
          // No 1 anywhere in the low bits means the input was 100..0,
          // whose magnitude does not fit; result_next is then all zero.
          if (cnt == LAST) begin
            state     <= DONE;
            magni     <= {1'b1, result_next};
            ovf       <= ~seen_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complement_to_magni_serial.sv
// ---------------------------------------------------------------------------
// tb_complement_to_magni_serial
//
// Self-checking bench for complement_to_magni_serial at WIDTH=5. A table of
// hand-computed vectors is run through the handshake, followed by directed
// sequences for backpressure, in_valid during SHIFT and reset mid-shift.
// ---------------------------------------------------------------------------
module tb_complement_to_magni_serial;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] compl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] magni;
  logic         ovf;
  logic         busy;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [W-1:0] compl;
    logic [W-1:0] magni;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  complement_to_magni_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .compl     (compl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .magni     (magni),
    .ovf       (ovf),
    .busy      (busy)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Pushes one word through, measures how many edges after the accept edge
  // it takes for out_valid to appear (0 means visible right after the accept
  // edge, i.e. seen at the next edge), optionally stalls the result for
  // 'hold' cycles, then drains it.
  task automatic apply_stimulus(input vec_t v, input int hold);
    int lat;
    check_output("in_ready_idle", in_ready, 1'b1);
    compl    = v.compl;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    compl    = '0;
    lat      = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      check_output("busy_shift", busy, 1'b1);
      @(posedge clk); #1;
      lat++;
    end
    check_output("latency", lat, v.lat);
    check_output("magni", magni, v.magni);
    check_output("ovf", ovf, v.ovf);
    check_output("busy_done", busy, 1'b1);
    check_output("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output("hold_out_valid", out_valid, 1'b1);
      check_output("hold_magni", magni, v.magni);
      check_output("hold_ovf", ovf, v.ovf);
      check_output("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("drain_out_valid", out_valid, 1'b0);
    check_output("drain_in_ready", in_ready, 1'b1);
    check_output("drain_busy", busy, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compl     = '0;

    // Negative words reach DONE on the 4th edge after accept (W-1 shifts).
    vecs[0] = '{5'b01011, 5'b01011, 1'b0, 0};
    vecs[1] = '{5'b11011, 5'b10101, 1'b0, 4};
    vecs[2] = '{5'b11111, 5'b10001, 1'b0, 4};
    vecs[3] = '{5'b10001, 5'b11111, 1'b0, 4};
    vecs[4] = '{5'b10110, 5'b11010, 1'b0, 4};
    vecs[5] = '{5'b10000, 5'b10000, 1'b1, 4};
    vecs[6] = '{5'b00000, 5'b00000, 1'b0, 0};
    vecs[7] = '{5'b01111, 5'b01111, 1'b0, 0};

    #12;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_magni", magni, 5'b00000);
    check_output("rst_ovf", ovf, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], 0);

    // Backpressure: result held for 3 stalled cycles
    apply_stimulus(vecs[1], 3);

    // in_valid held with new data during SHIFT must not be consumed early
    compl    = 5'b11011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    compl = 5'b00110;
    begin
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        check_output("ign_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        lat++;
      end
      check_output("ign_latency", lat, 4);
    end
    check_output("ign_magni", magni, 5'b10101);
    check_output("ign_ovf", ovf, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_output("ign_back_idle", in_ready, 1'b1);
    check_output("ign_no_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("ign_second_valid", out_valid, 1'b1);
    check_output("ign_second_magni", magni, 5'b00110);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Leave a non-zero ovf result in the output registers, then reset in
    // the 2nd SHIFT cycle of the next conversion.
    apply_stimulus(vecs[5], 0);
    compl    = 5'b11011;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("arst_busy", busy, 1'b0);
    check_output("arst_out_valid", out_valid, 1'b0);
    check_output("arst_magni", magni, 5'b00000);
    check_output("arst_ovf", ovf, 1'b0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("arst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check_output("arst_no_stale_valid", out_valid, 1'b0);
    check_output("arst_idle_busy", busy, 1'b0);

    // Normal operation after the aborted conversion
    apply_stimulus(vecs[3], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complement_to_magni_serial.md
Name: complement_to_magni_serial

Overview:
- Converts a WIDTH-bit two's-complement word into sign-magnitude form. This is the reverse of the sign-magnitude-to-complement conversion used elsewhere in the mini-project datapath.
- Negative inputs are negated bit-serially, LSB first, using the rule "copy bits up to and including the first 1, invert the rest". No WIDTH-wide adder is used.
- Valid/ready handshake on both sides. Sits between the arithmetic core and the sign-magnitude display/output stage.

Parameters:
- WIDTH, 5, total word width including the sign bit (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  compl holds a word to convert.
- in_ready  output  1  block can accept a word this cycle.
- compl  input  WIDTH  two's-complement operand.
- out_valid  output  1  magni/ovf hold a result.
- out_ready  input  1  downstream accepts the result this cycle.
- magni  output  WIDTH  sign-magnitude result; bit WIDTH-1 is the sign.
- ovf  output  1  result not representable (input is the most negative value).
- busy  output  1  conversion in progress (state is not IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, magni=0, ovf=0, busy=0; internal shift register, bit counter and seen_one flag cleared.
- Reset applied mid-conversion aborts the conversion; no partial result is ever presented.
- in_ready = (state==IDLE). It is combinational from state, so it is 1 in the first cycle after reset release.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Accept occurs when in_valid && in_ready at a clock edge. On accept: capture sign=compl[WIDTH-1] and the low WIDTH-1 bits into the shift register; clear counter and seen_one.
  - sign=0: go to DONE. magni=compl, ovf=0.
  - sign=1: go to SHIFT.
- SHIFT (exactly WIDTH-1 cycles), per cycle:
  - b = shift-register LSB.
  - Result bit = seen_one ? ~b : b.
  - seen_one |= b.
  - Result bit is shifted into the result register from the MSB side; counter increments.
  - After the last bit, go to DONE with magni = {1'b1, result}.
  - ovf = ~seen_one, i.e. the low bits were all zero (input 1000..0). In that case magni = 1000..0 and ovf=1.
- DONE:
  - out_valid=1. magni and ovf are held stable until out_ready=1 at a clock edge.
  - On that edge: go to IDLE, out_valid=0. magni/ovf keep their last value (don't-care while out_valid=0).
- Latency, from accept edge to the first edge where out_valid=1 is visible:
  - Non-negative input: 1 cycle.
  - Negative input: WIDTH cycles (5 at the default).
- Throughput: one word per (latency + 1) cycles minimum. No input is accepted in SHIFT or DONE; in_valid during those states is ignored and the word is not consumed.
- Zero input 00..0 converts to 00..0 with ovf=0. No negative zero is ever produced except the flagged ovf case.
- busy=1 in SHIFT and DONE.
- All state updates occur on the rising edge of clk; there are no combinational paths from compl to magni.

Test Plan:
- Reset, then compl=5'b01011 with in_valid=1, out_ready=1 -> out_valid=1 one cycle after accept, magni=01011, ovf=0.
- compl=5'b11011 (-5) -> busy for 4 SHIFT cycles; out_valid 5 cycles after accept; magni=10101, ovf=0. Also compl=11111 -> 10001, and compl=10001 -> 11111.
- compl=5'b10000 -> magni=10000, ovf=1. Then compl=00000 -> magni=00000, ovf=0.
- Backpressure: result pending, out_ready=0 for 3 cycles -> out_valid, magni, ovf stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 next cycle.
- in_valid held with new data during SHIFT -> ignored; that data is accepted only once back in IDLE; the first result is unaffected.
- rst_n pulsed low during the 2nd SHIFT cycle -> all outputs 0 immediately (asynchronous); after release in_ready=1 and no stale out_valid.
